// File: rtl/world_clock_pkg.sv
// world_clock_pkg: field selectors, limits and reset values shared by the world clock core
package world_clock_pkg;
  typedef enum logic [2:0] {
    F_SEC, F_MIN, F_HOUR, F_DAY, F_MONTH, F_YEAR_1, F_YEAR_2, F_NONE
  } set_field_e;
  localparam logic [6:0] MAX_SEC = 7'd59;
  localparam logic [6:0] MAX_MIN = 7'd59;
  localparam logic [6:0] MAX_HOUR = 7'd23;
  localparam logic [6:0] MAX_MONTH = 7'd12;
  localparam logic [6:0] MAX_YEAR = 7'd99;
  localparam logic [6:0] RST_DAY = 7'd1;
  localparam logic [6:0] RST_MONTH = 7'd1;
  localparam logic [6:0] RST_YEAR_1 = 7'd20;
  localparam logic [6:0] RST_YEAR_2 = 7'd0;
endpackage

// File: rtl/world_clock_timekeeper_month_len.sv
// month_len: days in a month; February gets 29 in leap years when WORLD_CLOCK_LEAP_YEAR_EN is defined
module month_len
  import world_clock_pkg::*;
(
  input  logic [6:0] month,
  input  logic [6:0] year_1,
  input  logic [6:0] year_2,
  output logic [4:0] len
);
  logic leap;
`ifdef WORLD_CLOCK_LEAP_YEAR_EN
  assign leap = year_2 != 7'd0 ? year_2[1:0] == 2'd0 : year_1[1:0] == 2'd0;
`else
  logic unused_year;
  assign leap = 1'b0;
  assign unused_year = ^{year_1, year_2};
`endif
  assign len = month == 7'd2 ? (leap ? 5'd29 : 5'd28) :
               (month == 7'd4 || month == 7'd6 || month == 7'd9 || month == 7'd11) ? 5'd30 : 5'd31;
endmodule

// File: rtl/world_clock_timekeeper.sv
// world_clock_timekeeper: 1 Hz calendar, zone-2 hour and display phase; leap years via WORLD_CLOCK_LEAP_YEAR_EN
module world_clock_timekeeper
  import world_clock_pkg::*;
#(
  parameter int CLK_HZ = 100,
  parameter int TIME_SECS = 8,
  parameter int DATE_SECS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_en,
  input  logic [2:0] set_field,
  input  logic [6:0] set_value,
  input  logic [4:0] zone_ofs,
  output logic [6:0] sec,
  output logic [6:0] min_1,
  output logic [6:0] hour_1,
  output logic [6:0] min_2,
  output logic [6:0] hour_2,
  output logic [6:0] day,
  output logic [6:0] month,
  output logic [6:0] year_1,
  output logic [6:0] year_2,
  output logic       show_time,
  output logic       sec_tick,
  output logic       set_err
);
  localparam int PW = $clog2(CLK_HZ);
  localparam int PH = TIME_SECS + DATE_SECS;
  localparam int HW = $clog2(PH + 1);
  logic [PW-1:0] pre;
  logic [HW-1:0] ph, ph_n;
  logic [4:0] len, len_new;
  logic [6:0] m_new, y1_new, y2_new;
  logic [7:0] zsum, zadj;
  logic tick, ok, zone_ok, c_s, c_m, c_h, c_d, c_mo, c_y2;
  set_field_e fld;
  assign fld = set_field_e'(set_field);
  month_len u_len (.month(month), .year_1(year_1), .year_2(year_2), .len(len));
  // length of the month the pending load would produce, for clamping day
  month_len u_len_new (.month(m_new), .year_1(y1_new), .year_2(y2_new), .len(len_new));
  always_comb begin
    tick = !set_en && pre == PW'(CLK_HZ - 1);
    c_s = sec == MAX_SEC;
    c_m = c_s && min_1 == MAX_MIN;
    c_h = c_m && hour_1 == MAX_HOUR;
    c_d = c_h && day >= {2'b0, len};
    c_mo = c_d && month == MAX_MONTH;
    c_y2 = c_mo && year_2 == MAX_YEAR;
    m_new = fld == F_MONTH ? set_value : month;
    y1_new = fld == F_YEAR_1 ? set_value : year_1;
    y2_new = fld == F_YEAR_2 ? set_value : year_2;
    ok = fld == F_SEC ? set_value <= MAX_SEC :
         fld == F_MIN ? set_value <= MAX_MIN :
         fld == F_HOUR ? set_value <= MAX_HOUR :
         fld == F_DAY ? set_value != 7'd0 && set_value <= {2'b0, len} :
         fld == F_MONTH ? set_value != 7'd0 && set_value <= MAX_MONTH :
         (fld == F_YEAR_1 || fld == F_YEAR_2) ? set_value <= MAX_YEAR : 1'b0;
    zone_ok = $signed(zone_ofs) >= -5'sd12 && $signed(zone_ofs) <= 5'sd14;
    // 8-bit wrap-around sum: bit 7 set means the raw result went negative
    zsum = {1'b0, hour_1} + (zone_ok ? {{3{zone_ofs[4]}}, zone_ofs} : 8'd0);
    zadj = zsum[7] ? zsum + 8'd24 : zsum >= 8'd24 ? zsum - 8'd24 : zsum;
    ph_n = ph == HW'(PH - 1) ? '0 : ph + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pre <= '0;
      ph <= '0;
      sec <= '0;
      min_1 <= '0;
      hour_1 <= '0;
      min_2 <= '0;
      hour_2 <= '0;
      day <= RST_DAY;
      month <= RST_MONTH;
      year_1 <= RST_YEAR_1;
      year_2 <= RST_YEAR_2;
      show_time <= 1'b1;
      sec_tick <= 1'b0;
      set_err <= 1'b0;
    end else begin
      min_2 <= min_1;
      hour_2 <= zadj[6:0];
      sec_tick <= tick;
      set_err <= set_en && !ok;
      if (set_en) begin
        ph <= '0;
        show_time <= 1'b1;
        if (ok) begin
          if (fld == F_SEC) begin
            sec <= set_value;
            pre <= '0;
          end
          if (fld == F_MIN) min_1 <= set_value;
          if (fld == F_HOUR) hour_1 <= set_value;
          if (fld == F_DAY) day <= set_value;
          if (fld == F_MONTH) month <= set_value;
          if (fld == F_YEAR_1) year_1 <= set_value;
          if (fld == F_YEAR_2) year_2 <= set_value;
          if ((fld == F_MONTH || fld == F_YEAR_1 || fld == F_YEAR_2) && day > {2'b0, len_new})
            day <= {2'b0, len_new};
        end
      end else begin
        pre <= tick ? '0 : pre + 1'b1;
        if (sec_tick) begin
          ph <= ph_n;
          show_time <= ph_n < HW'(TIME_SECS);
        end
        if (tick) begin
          sec <= c_s ? 7'd0 : sec + 7'd1;
          if (c_s) min_1 <= c_m ? 7'd0 : min_1 + 7'd1;
          if (c_m) hour_1 <= c_h ? 7'd0 : hour_1 + 7'd1;
          if (c_h) day <= c_d ? 7'd1 : day + 7'd1;
          if (c_d) month <= c_mo ? 7'd1 : month + 7'd1;
          if (c_mo) year_2 <= c_y2 ? 7'd0 : year_2 + 7'd1;
          if (c_y2) year_1 <= year_1 == MAX_YEAR ? 7'd0 : year_1 + 7'd1;
        end
      end
    end
  end
endmodule
